// File: rtl/deserialize_10b.sv
// Serial-to-10b deserializer with K28.5 comma word alignment and loss-of-lock tracking.
// Define DESER_REALIGN_EN to let a misaligned comma realign while locked.
module deserialize_10b #(
    parameter int LOSS_WORDS = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_enable,
    input  logic       d_in,
    output logic [9:0] d_out,
    output logic       word_valid,
    output logic       locked,
    output logic       comma_seen
);

    localparam int MW = $clog2(LOSS_WORDS + 1);
    localparam logic [MW-1:0] MISS_LAST = MW'(LOSS_WORDS - 1);
    localparam logic [9:0] COMMA_NEG = 10'b0011111010;
    localparam logic [9:0] COMMA_POS = 10'b1100000101;

    typedef enum logic {HUNT, LOCKED} state_t;

    state_t          state, state_n;
    logic [9:0]      sr, sr_n;
    logic [3:0]      bit_cnt, bit_cnt_n;
    logic [MW-1:0]   miss_cnt, miss_cnt_n;
    logic [9:0]      d_out_n;
    logic            word_valid_n, comma_seen_n, locked_n;
    logic [9:0]      candidate;
    logic            is_comma;

    assign candidate = {sr[8:0], d_in};
    assign is_comma  = (candidate == COMMA_NEG) || (candidate == COMMA_POS);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= HUNT;
            sr         <= '0;
            bit_cnt    <= '0;
            miss_cnt   <= '0;
            d_out      <= '0;
            word_valid <= 1'b0;
            comma_seen <= 1'b0;
            locked     <= 1'b0;
        end else begin
            state      <= state_n;
            sr         <= sr_n;
            bit_cnt    <= bit_cnt_n;
            miss_cnt   <= miss_cnt_n;
            d_out      <= d_out_n;
            word_valid <= word_valid_n;
            comma_seen <= comma_seen_n;
            locked     <= locked_n;
        end
    end

    always_comb begin
        state_n      = state;
        sr_n         = sr;
        bit_cnt_n    = bit_cnt;
        miss_cnt_n   = miss_cnt;
        d_out_n      = d_out;
        word_valid_n = 1'b0;
        comma_seen_n = 1'b0;
        if (bit_enable) begin
            sr_n = candidate;
            case (state)
                HUNT: begin
                    if (is_comma) begin
                        d_out_n      = candidate;
                        word_valid_n = 1'b1;
                        comma_seen_n = 1'b1;
                        bit_cnt_n    = '0;
                        miss_cnt_n   = '0;
                        state_n      = LOCKED;
                    end
                end
                LOCKED: begin
                    if (bit_cnt == 4'd9) begin
                        d_out_n      = candidate;
                        word_valid_n = 1'b1;
                        bit_cnt_n    = '0;
                        if (is_comma) begin
                            comma_seen_n = 1'b1;
                            miss_cnt_n   = '0;
                        end else if (miss_cnt == MISS_LAST) begin
                            // Last tolerated miss: word still goes out, lock drops now
                            miss_cnt_n = '0;
                            state_n    = HUNT;
                        end else begin
                            miss_cnt_n = miss_cnt + 1'b1;
                        end
                    end else begin
`ifdef DESER_REALIGN_EN
                        if (is_comma) begin
                            d_out_n      = candidate;
                            word_valid_n = 1'b1;
                            comma_seen_n = 1'b1;
                            bit_cnt_n    = '0;
                            miss_cnt_n   = '0;
                        end else begin
                            bit_cnt_n = bit_cnt + 4'd1;
                        end
`else
                        bit_cnt_n = bit_cnt + 4'd1;
`endif
                    end
                end
                default: state_n = HUNT;
            endcase
        end
        locked_n = (state_n == LOCKED);
    end

endmodule
